// File: rtl/xor_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial XOR unit.
// Ports: CLK/RST, REQx/Ax/Bx in; GNTx, BUSY, DONE, Y, ID out.

module xor_gate (
    input  logic A,
    input  logic B,
    output logic C
);
    assign C = A ^ B;
endmodule

module xor_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic             ID
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             win;
    logic             bit_c;

    xor_gate u_xor (
        .A (a_q[0]),
        .B (b_q[0]),
        .C (bit_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        y_d     = y_q;
        id_d    = id_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        win     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    // Under contention the requester not served last wins.
                    win     = (REQ0 && REQ1) ? ~last_q : REQ1;
                    sel_d   = win;
                    a_d     = win ? A1 : A0;
                    b_d     = win ? B1 : B0;
                    r_d     = '0;
                    cnt_d   = '0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // LSB-first: result enters at the MSB and walks down.
                r_d   = {bit_c, r_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    y_d     = r_d;
                    id_d    = sel_q;
                    last_d  = sel_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            y_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            y_q     <= y_d;
            id_q    <= id_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    assign GNT0 = gnt0_q;
    assign GNT1 = gnt1_q;
    assign BUSY = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign DONE = (state_q == S_DONE);
    assign Y    = y_q;
    assign ID   = id_q;

endmodule

// File: tb/tb_xor_arbiter.sv
// Directed bench for xor_arbiter with a result scoreboard.
// Expected {ID,Y} pushed at request time, popped on DONE.

module tb_xor_arbiter;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         REQ0 = 1'b0;
    logic         REQ1 = 1'b0;
    logic [W-1:0] A0 = '0;
    logic [W-1:0] B0 = '0;
    logic [W-1:0] A1 = '0;
    logic [W-1:0] B1 = '0;
    logic         GNT0, GNT1, BUSY, DONE, ID;
    logic [W-1:0] Y;

    int checks = 0;
    int fails  = 0;
    int busy_cnt = 0;
    logic [W:0]   sb[$];
    logic [W:0]   exp_e;
    logic [W-1:0] y_hold = '0;
    logic         id_hold = 1'b0;
    bit           model_last = 1'b1;

    xor_arbiter #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ0 (REQ0),
        .A0   (A0),
        .B0   (B0),
        .REQ1 (REQ1),
        .A1   (A1),
        .B1   (B1),
        .GNT0 (GNT0),
        .GNT1 (GNT1),
        .BUSY (BUSY),
        .DONE (DONE),
        .Y    (Y),
        .ID   (ID)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST) begin
            busy_cnt = 0;
            y_hold   = '0;
            id_hold  = 1'b0;
        end else begin
            checks++;
            assert (!(GNT0 && GNT1)) else begin
                fails++;
                $error("FAIL gnt_excl: GNT0=%0b GNT1=%0b, required not both", GNT0, GNT1);
            end
            if (BUSY) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                checks++;
                assert (busy_cnt == W + 1) else begin
                    fails++;
                    $error("FAIL busy_len: got %0d, required %0d", busy_cnt, W + 1);
                end
                busy_cnt = 0;
            end
            if (DONE) begin
                checks++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL done_unexp: DONE=1 with no job expected");
                end
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    checks++;
                    assert (Y === exp_e[W-1:0]) else begin
                        fails++;
                        $error("FAIL y: got %h, required %h", Y, exp_e[W-1:0]);
                    end
                    checks++;
                    assert (ID === exp_e[W]) else begin
                        fails++;
                        $error("FAIL id: got %0b, required %0b", ID, exp_e[W]);
                    end
                    y_hold  = exp_e[W-1:0];
                    id_hold = exp_e[W];
                end
            end else begin
                checks++;
                assert (Y === y_hold && ID === id_hold) else begin
                    fails++;
                    $error("FAIL hold: Y=%h ID=%0b, required Y=%h ID=%0b",
                           Y, ID, y_hold, id_hold);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] req);
        checks++;
        assert (got === req) else begin
            fails++;
            $error("FAIL %s: got %h, required %h", tag, got, req);
        end
    endtask

    task automatic wait_gnt(input bit exp_idx, output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            if (GNT0 || GNT1) begin
                lat = i;
                got = 1'b1;
                break;
            end
        end
        chk("gnt_seen", W'(got), W'(1));
        if (got) begin
            chk("gnt1", W'(GNT1), W'(exp_idx));
            chk("gnt0", W'(GNT0), W'(!exp_idx));
        end
    endtask

    task automatic wait_done(input bit scramble);
        bit got = 1'b0;
        int lat = 0;
        for (int i = 1; i <= W + 3; i++) begin
            @(negedge CLK);
            if (DONE) begin
                lat = i;
                got = 1'b1;
                break;
            end
            if (scramble) begin
                A0 = W'($urandom);
                B0 = W'($urandom);
                A1 = W'($urandom);
                B1 = W'($urandom);
            end
        end
        chk("done_seen", W'(got), W'(1));
        chk("done_lat", W'(lat), W'(W));
    endtask

    // Called at a negedge; drives a request and runs it to DONE.
    task automatic do_job(input bit r0, input bit r1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input int exp_lat, input bit scramble,
                          input bit drop);
        bit win;
        int lat;
        REQ0 = r0;
        REQ1 = r1;
        A0 = a0;
        B0 = b0;
        A1 = a1;
        B1 = b1;
        win = (r0 && r1) ? !model_last : r1;
        sb.push_back({win, win ? (a1 ^ b1) : (a0 ^ b0)});
        wait_gnt(win, lat);
        chk("gnt_lat", W'(lat), W'(exp_lat));
        if (drop) begin
            if (win) REQ1 = 1'b0;
            else REQ0 = 1'b0;
        end
        wait_done(scramble);
        model_last = win;
    endtask

    logic [W-1:0] pats [4];
    int lat_r;

    initial begin
        pats[0] = 8'h00;
        pats[1] = 8'hFF;
        pats[2] = 8'hAA;
        pats[3] = 8'h55;

        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_gnt0", W'(GNT0), W'(0));
        chk("rst_gnt1", W'(GNT1), W'(0));
        chk("rst_busy", W'(BUSY), W'(0));
        chk("rst_done", W'(DONE), W'(0));
        chk("rst_y", Y, W'(0));
        chk("rst_id", W'(ID), W'(0));
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);

        do_job(1, 0, 8'hA5, 8'h3C, 8'h00, 8'h00, 1, 0, 1);

        do_job(1, 1, 8'h12, 8'h34, 8'hFF, 8'h0F, 2, 0, 1);
        do_job(0, 1, 8'h12, 8'h34, 8'hFF, 8'h0F, 2, 0, 1);

        for (int k = 0; k < 4; k++)
            do_job(1, 1, W'(8'h11 * k), 8'h5A, W'(8'h21 + k), 8'hC3, 2, 0, 0);
        REQ0 = 1'b0;
        REQ1 = 1'b0;

        do_job(1, 0, 8'h12, 8'h34, 8'h00, 8'h00, 2, 1, 1);

        REQ1 = 1'b1;
        A1 = 8'hF0;
        B1 = 8'h0F;
        wait_gnt(1'b1, lat_r);
        REQ1 = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        model_last = 1'b1;
        @(negedge CLK);
        chk("abort_busy", W'(BUSY), W'(0));
        chk("abort_done", W'(DONE), W'(0));
        chk("abort_y", Y, W'(0));
        do_job(0, 1, 8'h00, 8'h00, 8'h3C, 8'h66, 1, 0, 1);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                if (((i + j) % 2) == 0)
                    do_job(1, 0, pats[i], pats[j], 8'h00, 8'h00, 2, 0, 1);
                else
                    do_job(0, 1, 8'h00, 8'h00, pats[i], pats[j], 2, 0, 1);
            end

        repeat (4) @(negedge CLK);
        chk("sb_empty", W'(sb.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
